// File: rtl/csr_pkg.sv
// Shared definitions for the CSR access unit: Zicsr funct3 encodings,
// well-known CSR addresses and the access FSM state encoding.
package csr_pkg;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_TIME     = 12'hC01;
  localparam logic [11:0] CSR_TIMEH    = 12'hC81;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADDR  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/csr_op_decode.sv
// Combinational Zicsr operation classifier. The CSR file only supports
// read and OR-set, so write and non-trivial clear forms are flagged illegal.
// Optional macro CSR_RO_CHECK_EN: reject set-writes into read-only space
// (addr[11:10] == 2'b11).
module csr_op_decode
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] mask,
  input  logic [11:0]     addr,
  output logic            is_set,
  output logic            is_write,
  output logic            illegal
);

  logic mask_nz;
  logic decode_unused;

  // Bit 2 only selects the mask source upstream; the address is used only
  // by the optional read-only check.
  assign decode_unused = funct3[2] ^ (^addr);

  // Classify the op and flag anything the CSR file cannot perform.
  always_comb begin
    mask_nz  = |mask;
    is_set   = (funct3[1:0] == 2'b10);
    is_write = is_set && mask_nz;
    illegal  = 1'b0;
    case (funct3[1:0])
      2'b00:   illegal = 1'b1;    // 000 / 100 are not Zicsr ops
      2'b01:   illegal = 1'b1;    // overwrite forms unsupported
      2'b11:   illegal = mask_nz; // clear with zero mask is a pure read
      default: illegal = 1'b0;
    endcase
`ifdef CSR_RO_CHECK_EN
    if (is_write && (addr[11:10] == 2'b11)) illegal = 1'b1;
`endif
  end

endmodule

// File: rtl/csr_access_unit.sv
// Initiator side of the CSR interface: runs one Zicsr instruction at a time,
// IDLE -> ADDR (READ_WAIT cycles) -> WRITE -> RESP, returning the old CSR
// value to the register file.
// Optional macro CSR_RO_CHECK_EN (see csr_op_decode) enables the
// read-only address check.
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int READ_WAIT = 1,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            res,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [11:0]     csr_addr_in,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [4:0]      uimm,
  input  logic [4:0]      rd_in,
  output logic            csr_request,
  output logic [11:0]     csr_A,
  output logic [XLEN-1:0] csr_mode,
  input  logic [XLEN-1:0] csr_Q,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic            rd_we,
  output logic [4:0]      rd_waddr,
  output logic [XLEN-1:0] rd_wdata
);

  localparam logic [3:0] RW_CNT = 4'(READ_WAIT);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [11:0]     addr_q, addr_d;
  logic [XLEN-1:0] mask_q, mask_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] old_q, old_d;

  logic [XLEN-1:0] mask_in;
  logic            dec_is_set, dec_is_write, dec_illegal;
  logic            do_req;

  assign mask_in = funct3[2] ? {{(XLEN-5){1'b0}}, uimm} : rs1_data;

  csr_op_decode #(.XLEN(XLEN)) u_dec (
    .funct3   (f3_q),
    .mask     (mask_q),
    .addr     (addr_q),
    .is_set   (dec_is_set),
    .is_write (dec_is_write),
    .illegal  (dec_illegal)
  );

  assign do_req = dec_is_set && dec_is_write && !dec_illegal;

  // Next-state logic: latch the command in IDLE, count out the read wait,
  // capture the old value on the last ADDR edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    rd_d    = rd_q;
    old_d   = old_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d    = funct3;
          addr_d  = csr_addr_in;
          mask_d  = mask_in;
          rd_d    = rd_in;
          cnt_d   = RW_CNT;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (cnt_q <= 4'd1) begin
          old_d   = csr_Q;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and command registers; reset aborts any command in flight.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      rd_q    <= '0;
      old_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      rd_q    <= rd_d;
      old_q   <= old_d;
    end
  end

  // Outputs decoded from state so that reset forces them all low at once.
  always_comb begin
    csr_request = 1'b0;
    csr_A       = '0;
    csr_mode    = '0;
    busy        = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    rd_we       = 1'b0;
    rd_waddr    = '0;
    rd_wdata    = '0;
    case (state_q)
      S_ADDR: begin
        busy  = 1'b1;
        csr_A = addr_q;
      end
      S_WRITE: begin
        busy  = 1'b1;
        csr_A = addr_q;
        if (do_req) begin
          csr_request = 1'b1;
          csr_mode    = mask_q;
        end
      end
      S_RESP: begin
        busy = 1'b1;
        done = 1'b1;
        if (dec_illegal) begin
          illegal = 1'b1;
        end else if (rd_q != 5'd0) begin
          rd_we    = 1'b1;
          rd_waddr = rd_q;
          rd_wdata = old_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit. Two instances: READ_WAIT=1 and
// READ_WAIT=4, sharing command inputs; sel picks which one is exercised.
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        res;
  logic        start_r, sel;
  logic [2:0]  funct3;
  logic [11:0] csr_addr_in;
  logic [31:0] rs1_data, q_drv;
  logic [4:0]  uimm, rd_in;

  logic        req1, busy1, done1, ill1, we1;
  logic [11:0] a1;
  logic [31:0] mode1, wd1;
  logic [4:0]  wa1;
  logic        req4, busy4, done4, ill4, we4;
  logic [11:0] a4;
  logic [31:0] mode4, wd4;
  logic [4:0]  wa4;

  logic        o_req, o_busy, o_done, o_ill, o_we;
  logic [11:0] o_a;
  logic [31:0] o_mode, o_wd;
  logic [4:0]  o_wa;

  always #5 clk = ~clk;

  csr_access_unit #(.READ_WAIT(1), .XLEN(32)) u_dut1 (
    .clk(clk), .res(res), .start(start_r && !sel), .funct3(funct3),
    .csr_addr_in(csr_addr_in), .rs1_data(rs1_data), .uimm(uimm), .rd_in(rd_in),
    .csr_request(req1), .csr_A(a1), .csr_mode(mode1), .csr_Q(q_drv),
    .busy(busy1), .done(done1), .illegal(ill1), .rd_we(we1),
    .rd_waddr(wa1), .rd_wdata(wd1));

  csr_access_unit #(.READ_WAIT(4), .XLEN(32)) u_dut4 (
    .clk(clk), .res(res), .start(start_r && sel), .funct3(funct3),
    .csr_addr_in(csr_addr_in), .rs1_data(rs1_data), .uimm(uimm), .rd_in(rd_in),
    .csr_request(req4), .csr_A(a4), .csr_mode(mode4), .csr_Q(q_drv),
    .busy(busy4), .done(done4), .illegal(ill4), .rd_we(we4),
    .rd_waddr(wa4), .rd_wdata(wd4));

  assign o_req  = sel ? req4  : req1;
  assign o_a    = sel ? a4    : a1;
  assign o_mode = sel ? mode4 : mode1;
  assign o_busy = sel ? busy4 : busy1;
  assign o_done = sel ? done4 : done1;
  assign o_ill  = sel ? ill4  : ill1;
  assign o_we   = sel ? we4   : we1;
  assign o_wa   = sel ? wa4   : wa1;
  assign o_wd   = sel ? wd4   : wd1;

  typedef struct {
    int          lat;
    int          req_cnt;
    logic [11:0] ra;
    logic [31:0] rmode;
    logic        ill;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } exp_t;

  exp_t exp_q[$];
  exp_t ex;

  int n_chk = 0;
  int n_fail = 0;

  // observations from the last run_op
  int          ob_lat, ob_done_cnt, ob_req_cnt;
  logic        ob_busy_after, ob_ill, ob_we;
  logic [11:0] ob_ra;
  logic [31:0] ob_rmode, ob_wd;
  logic [4:0]  ob_wa;

  // Drive one command on the selected instance and record what comes back.
  // q_good is presented only in the final ADDR cycle; q_bad otherwise.
  task automatic run_op(input bit s, input logic [2:0] f3, input logic [11:0] addr,
                        input logic [31:0] rs1, input logic [4:0] imm,
                        input logic [4:0] rd, input logic [31:0] q_good,
                        input logic [31:0] q_bad, input int restart_at);
    int rw;
    rw = s ? 4 : 1;
    sel = s;
    @(negedge clk);
    funct3 = f3; csr_addr_in = addr; rs1_data = rs1; uimm = imm; rd_in = rd;
    start_r = 1'b1;
    @(posedge clk);
    #1;
    start_r = 1'b0;
    // scramble command inputs: the unit must use its latched copy
    funct3 = 3'b001; csr_addr_in = ~addr; rs1_data = ~rs1; uimm = ~imm; rd_in = ~rd;
    q_drv = q_bad;
    ob_lat = -1; ob_done_cnt = 0; ob_req_cnt = 0; ob_busy_after = 1'b1;
    ob_ill = 1'b0; ob_we = 1'b0; ob_wa = '0; ob_wd = '0; ob_ra = '0; ob_rmode = '0;
    for (int cyc = 1; cyc <= rw + 8; cyc++) begin
      @(negedge clk);
      q_drv   = (cyc == rw) ? q_good : q_bad;
      start_r = (cyc == restart_at);
      if (o_req) begin
        ob_req_cnt++;
        ob_ra = o_a;
        ob_rmode = o_mode;
      end
      if (o_done) begin
        ob_done_cnt++;
        if (ob_lat < 0) begin
          ob_lat = cyc; ob_ill = o_ill; ob_we = o_we; ob_wa = o_wa; ob_wd = o_wd;
        end
      end
      if (ob_lat >= 0 && cyc == ob_lat + 1) ob_busy_after = o_busy;
    end
    start_r = 1'b0;
  endtask

  task automatic test_reset;
    res = 1'b1; start_r = 1'b0; sel = 1'b0; funct3 = '0; csr_addr_in = '0;
    rs1_data = '0; uimm = '0; rd_in = '0; q_drv = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({req1, a1, mode1, busy1, done1, ill1, we1, wa1, wd1} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut1: outputs=%h required 0", {req1, a1, mode1, busy1, done1, ill1, we1, wa1, wd1});
    end
    n_chk++;
    if ({req4, a4, mode4, busy4, done4, ill4, we4, wa4, wd4} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut4: outputs=%h required 0", {req4, a4, mode4, busy4, done4, ill4, we4, wa4, wd4});
    end
    res = 1'b0;
  endtask

  task automatic test_csrrs_read;
    exp_q.push_back('{lat: 3, req_cnt: 0, ra: '0, rmode: '0, ill: 1'b0, we: 1'b1, wa: 5'd5, wd: 32'h1});
    run_op(1'b0, csr_pkg::F3_RS, csr_pkg::CSR_MHARTID, 32'h0, 5'd0, 5'd5, 32'h1, 32'hBAD0_BAD0, 0);
    ex = exp_q.pop_front();
    n_chk++; if (ob_lat !== ex.lat) begin n_fail++; $display("FAIL rs_latency: got %0d required %0d", ob_lat, ex.lat); end
    n_chk++; if (ob_req_cnt !== ex.req_cnt) begin n_fail++; $display("FAIL rs_req: got %0d required %0d", ob_req_cnt, ex.req_cnt); end
    n_chk++; if (ob_we !== ex.we || ob_wa !== ex.wa) begin n_fail++; $display("FAIL rs_we: got we=%b wa=%0d required we=%b wa=%0d", ob_we, ob_wa, ex.we, ex.wa); end
    n_chk++; if (ob_wd !== ex.wd) begin n_fail++; $display("FAIL rs_wdata: got %h required %h", ob_wd, ex.wd); end
    n_chk++; if (ob_ill !== ex.ill) begin n_fail++; $display("FAIL rs_illegal: got %b required %b", ob_ill, ex.ill); end
  endtask

  task automatic test_csrrsi;
`ifdef CSR_RO_CHECK_EN
    exp_q.push_back('{lat: 3, req_cnt: 0, ra: '0, rmode: '0, ill: 1'b1, we: 1'b0, wa: '0, wd: '0});
`else
    exp_q.push_back('{lat: 3, req_cnt: 1, ra: 12'hC00, rmode: 32'h14, ill: 1'b0, we: 1'b1, wa: 5'd7, wd: 32'h100});
`endif
    run_op(1'b0, csr_pkg::F3_RSI, csr_pkg::CSR_CYCLE, 32'hFFFF_FFFF, 5'h14, 5'd7, 32'h100, 32'hBAD0_BAD0, 0);
    ex = exp_q.pop_front();
    n_chk++; if (ob_req_cnt !== ex.req_cnt) begin n_fail++; $display("FAIL rsi_req_cnt: got %0d required %0d", ob_req_cnt, ex.req_cnt); end
    n_chk++; if (ob_ra !== ex.ra || ob_rmode !== ex.rmode) begin n_fail++; $display("FAIL rsi_req_fields: got A=%h mode=%h required A=%h mode=%h", ob_ra, ob_rmode, ex.ra, ex.rmode); end
    n_chk++; if (ob_ill !== ex.ill || ob_we !== ex.we) begin n_fail++; $display("FAIL rsi_resp: got ill=%b we=%b required ill=%b we=%b", ob_ill, ob_we, ex.ill, ex.we); end
    n_chk++; if (ob_wa !== ex.wa || ob_wd !== ex.wd) begin n_fail++; $display("FAIL rsi_wdata: got wa=%0d wd=%h required wa=%0d wd=%h", ob_wa, ob_wd, ex.wa, ex.wd); end
  endtask

  task automatic test_illegal;
    exp_q.push_back('{lat: 3, req_cnt: 0, ra: '0, rmode: '0, ill: 1'b1, we: 1'b0, wa: '0, wd: '0});
    run_op(1'b0, csr_pkg::F3_RW, csr_pkg::CSR_INSTRET, 32'hFFFF, 5'd0, 5'd1, 32'h55, 32'hBAD0_BAD0, 0);
    ex = exp_q.pop_front();
    n_chk++; if (ob_lat !== ex.lat || ob_ill !== ex.ill) begin n_fail++; $display("FAIL rw_illegal: got lat=%0d ill=%b required lat=%0d ill=%b", ob_lat, ob_ill, ex.lat, ex.ill); end
    n_chk++; if (ob_req_cnt !== ex.req_cnt || ob_we !== ex.we) begin n_fail++; $display("FAIL rw_noeffect: got req=%0d we=%b required req=%0d we=%b", ob_req_cnt, ob_we, ex.req_cnt, ex.we); end
    // funct3 000 and 100 are illegal regardless of mask
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('{lat: 3, req_cnt: 0, ra: '0, rmode: '0, ill: 1'b1, we: 1'b0, wa: '0, wd: '0});
      run_op(1'b0, (k == 0) ? 3'b000 : 3'b100, 12'h300, 32'h0, 5'd3, 5'd2, 32'h77, 32'h77, 0);
      ex = exp_q.pop_front();
      n_chk++; if (ob_ill !== ex.ill || ob_we !== ex.we || ob_req_cnt !== ex.req_cnt) begin n_fail++; $display("FAIL f3_reserved_%0d: got ill=%b we=%b req=%0d required ill=%b we=%b req=%0d", k, ob_ill, ob_we, ob_req_cnt, ex.ill, ex.we, ex.req_cnt); end
    end
    // clear with nonzero mask is rejected
    exp_q.push_back('{lat: 3, req_cnt: 0, ra: '0, rmode: '0, ill: 1'b1, we: 1'b0, wa: '0, wd: '0});
    run_op(1'b0, csr_pkg::F3_RCI, 12'h300, 32'h0, 5'd1, 5'd6, 32'h77, 32'h77, 0);
    ex = exp_q.pop_front();
    n_chk++; if (ob_ill !== ex.ill || ob_we !== ex.we || ob_req_cnt !== ex.req_cnt) begin n_fail++; $display("FAIL rci_nonzero: got ill=%b we=%b req=%0d required ill=%b we=%b req=%0d", ob_ill, ob_we, ob_req_cnt, ex.ill, ex.we, ex.req_cnt); end
  endtask

  task automatic test_csrrc_read;
    exp_q.push_back('{lat: 3, req_cnt: 0, ra: '0, rmode: '0, ill: 1'b0, we: 1'b1, wa: 5'd3, wd: 32'h1234_5678});
    run_op(1'b0, csr_pkg::F3_RC, csr_pkg::CSR_TIMEH, 32'h0, 5'd0, 5'd3, 32'h1234_5678, 32'hBAD0_BAD0, 0);
    ex = exp_q.pop_front();
    n_chk++; if (ob_ill !== ex.ill || ob_req_cnt !== ex.req_cnt) begin n_fail++; $display("FAIL rc_read: got ill=%b req=%0d required ill=%b req=%0d", ob_ill, ob_req_cnt, ex.ill, ex.req_cnt); end
    n_chk++; if (ob_we !== ex.we || ob_wa !== ex.wa || ob_wd !== ex.wd) begin n_fail++; $display("FAIL rc_wdata: got we=%b wa=%0d wd=%h required we=%b wa=%0d wd=%h", ob_we, ob_wa, ob_wd, ex.we, ex.wa, ex.wd); end
    exp_q.push_back('{lat: 3, req_cnt: 0, ra: '0, rmode: '0, ill: 1'b0, we: 1'b0, wa: '0, wd: '0});
    run_op(1'b0, csr_pkg::F3_RC, csr_pkg::CSR_TIMEH, 32'h0, 5'd0, 5'd0, 32'h1234_5678, 32'hBAD0_BAD0, 0);
    ex = exp_q.pop_front();
    n_chk++; if (ob_lat !== ex.lat || ob_we !== ex.we || ob_ill !== ex.ill) begin n_fail++; $display("FAIL rc_x0: got lat=%0d we=%b ill=%b required lat=%0d we=%b ill=%b", ob_lat, ob_we, ob_ill, ex.lat, ex.we, ex.ill); end
  endtask

  task automatic test_back_to_back;
    exp_q.push_back('{lat: 6, req_cnt: 0, ra: '0, rmode: '0, ill: 1'b0, we: 1'b1, wa: 5'd9, wd: 32'hA5A5_0004});
    run_op(1'b1, csr_pkg::F3_RS, csr_pkg::CSR_TIME, 32'h0, 5'd0, 5'd9, 32'hA5A5_0004, 32'hDEAD_BEEF, 2);
    ex = exp_q.pop_front();
    n_chk++; if (ob_lat !== ex.lat) begin n_fail++; $display("FAIL b2b_latency: got %0d required %0d", ob_lat, ex.lat); end
    n_chk++; if (ob_done_cnt !== 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d required 1", ob_done_cnt); end
    n_chk++; if (ob_wd !== ex.wd || ob_we !== ex.we) begin n_fail++; $display("FAIL b2b_sample: got we=%b wd=%h required we=%b wd=%h", ob_we, ob_wd, ex.we, ex.wd); end
    n_chk++; if (ob_busy_after !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_drop: got %b required 0", ob_busy_after); end
  endtask

  task automatic test_wide_mask;
    exp_q.push_back('{lat: 6, req_cnt: 1, ra: 12'h300, rmode: 32'h8000_0001, ill: 1'b0, we: 1'b1, wa: 5'd31, wd: 32'h0000_1800});
    run_op(1'b1, csr_pkg::F3_RS, 12'h300, 32'h8000_0001, 5'd0, 5'd31, 32'h0000_1800, 32'hDEAD_BEEF, 0);
    ex = exp_q.pop_front();
    n_chk++; if (ob_req_cnt !== ex.req_cnt || ob_ra !== ex.ra || ob_rmode !== ex.rmode) begin n_fail++; $display("FAIL wide_req: got cnt=%0d A=%h mode=%h required cnt=%0d A=%h mode=%h", ob_req_cnt, ob_ra, ob_rmode, ex.req_cnt, ex.ra, ex.rmode); end
    n_chk++; if (ob_wa !== ex.wa || ob_wd !== ex.wd) begin n_fail++; $display("FAIL wide_wdata: got wa=%0d wd=%h required wa=%0d wd=%h", ob_wa, ob_wd, ex.wa, ex.wd); end
  endtask

  task automatic test_reset_mid;
    int dn, wn;
    sel = 1'b1;
    @(negedge clk);
    funct3 = csr_pkg::F3_RS; csr_addr_in = 12'h300; rs1_data = 32'hF; uimm = '0; rd_in = 5'd4;
    q_drv = 32'h42;
    start_r = 1'b1;
    @(posedge clk);
    #1 start_r = 1'b0;
    repeat (5) @(negedge clk);   // now in WRITE
    n_chk++; if (req4 !== 1'b1) begin n_fail++; $display("FAIL mid_in_write: got req=%b required 1", req4); end
    res = 1'b1;
    #1;
    n_chk++;
    if ({req4, a4, mode4, busy4, done4, ill4, we4, wa4, wd4} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h required 0", {req4, a4, mode4, busy4, done4, ill4, we4, wa4, wd4});
    end
    @(negedge clk);
    res = 1'b0;
    dn = 0; wn = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done4) dn++;
      if (we4 || req4) wn++;
    end
    n_chk++; if (dn !== 0 || wn !== 0) begin n_fail++; $display("FAIL mid_aborted: got done=%0d we_or_req=%0d required 0 0", dn, wn); end
    exp_q.push_back('{lat: 6, req_cnt: 0, ra: '0, rmode: '0, ill: 1'b0, we: 1'b1, wa: 5'd4, wd: 32'h0000_0042});
    run_op(1'b1, csr_pkg::F3_RS, 12'h300, 32'h0, 5'd0, 5'd4, 32'h42, 32'hDEAD_BEEF, 0);
    ex = exp_q.pop_front();
    n_chk++; if (ob_lat !== ex.lat || ob_we !== ex.we || ob_wd !== ex.wd) begin n_fail++; $display("FAIL mid_recover: got lat=%0d we=%b wd=%h required lat=%0d we=%b wd=%h", ob_lat, ob_we, ob_wd, ex.lat, ex.we, ex.wd); end
  endtask

  initial begin
    test_reset();
    test_csrrs_read();
    test_csrrsi();
    test_illegal();
    test_csrrc_read();
    test_back_to_back();
    test_wide_mask();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
